lcd_pattern_gen: RTL and testbench

//   Pixel source that sits directly upstream of the LCD timing driver.

---
 rtl/lcd_pkg.sv | 57 +++++
 rtl/lcd_pattern_gen_key_debounce.sv | 60 ++++++
 rtl/lcd_pattern_gen.sv | 175 +++++++++++++++++
 tb/tb_lcd_pattern_gen.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
//   Shared constants and types for the LCD test-pattern source:
//   default active-area size, pattern mode encodings, box motion direction,
//   bar colours and the box-mode background colour.
//   Colours are packed {B,G,R}: [7:0]=R, [15:8]=G, [23:16]=B.
// ---------------------------------------------------------------------------
package lcd_pkg;

  localparam int LCD_H_DISPLAY = 480;
  localparam int LCD_V_DISPLAY = 272;

  typedef enum logic [1:0] {
    MODE_BARS = 2'd0,
    MODE_GRID = 2'd1,
    MODE_BOX  = 2'd2
  } mode_t;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  localparam logic [23:0] RGB_WHITE      = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW     = 24'h00FFFF;
  localparam logic [23:0] RGB_CYAN       = 24'hFFFF00;
  localparam logic [23:0] RGB_GREEN      = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA    = 24'hFF00FF;
  localparam logic [23:0] RGB_RED        = 24'h0000FF;
  localparam logic [23:0] RGB_BLUE       = 24'hFF0000;
  localparam logic [23:0] RGB_BLACK      = 24'h000000;
  localparam logic [23:0] RGB_BACKGROUND = 24'h202020;

  // Bar colours, left to right.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

  // BARS -> GRID -> BOX -> BARS; the unused code 3 restarts at GRID like BARS.
  function automatic logic [1:0] next_mode(input logic [1:0] m);
    case (m)
      MODE_GRID: return MODE_BOX;
      MODE_BOX:  return MODE_BARS;
      default:   return MODE_GRID;
    endcase
  endfunction

endpackage

// File: rtl/lcd_pattern_gen_key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//   Synchronises an asynchronous active-low push-button and accepts a new
//   level only after it has been stable for DEB_CYCLES clocks.
//   Ports:
//     clk    in  pixel clock
//     rst_n  in  asynchronous reset, active low
//     key_n  in  raw push-button, active low
//     press  out one-cycle pulse on an accepted released->pressed transition
// ---------------------------------------------------------------------------
module key_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             accepted;   // 1 = pressed
  logic [CNT_W-1:0] cnt;
  logic             level;
  logic             mismatch;
  logic             settle;

  assign level    = ~sync2;
  assign mismatch = (level != accepted);
  assign settle   = mismatch && (cnt == CNT_LAST);
  assign press    = settle && level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Synchroniser resets to the released level so reset release never
      // looks like a press.
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      accepted <= 1'b0;
      cnt      <= '0;
    end else begin
      // NOTE: non-blocking assignments let sync2 take the old sync1, forming
      // a real two-stage shift; blocking would collapse it to one stage.
      sync1 <= key_n;
      sync2 <= sync1;
      if (!mismatch) begin
        cnt <= '0;
      end else if (settle) begin
        accepted <= level;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/lcd_pattern_gen.sv
// ---------------------------------------------------------------------------
// lcd_pattern_gen
//   Zero-latency pixel source for the LCD timing driver. Produces colour
//   bars, a grid, or a bouncing box; the box moves once per frame and a
//   debounced push-button steps through the patterns at frame boundaries.
//   Ports:
//     clk        in   pixel clock (shared with the driver)
//     rst_n      in   asynchronous reset, active low
//     lcd_de     in   display enable from the driver
//     lcd_vsync  in   vertical sync from the driver, active low
//     pixel_x    in   current column
//     pixel_y    in   current line
//     key_n      in   push-button, active low, asynchronous
//     rgb_data   out  colour {B,G,R}
//     mode       out  active pattern (0=BARS 1=GRID 2=BOX)
//     frame_tick out  one-cycle pulse per frame (vsync falling edge)
// ---------------------------------------------------------------------------
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int          H_DISPLAY  = LCD_H_DISPLAY,
  parameter int          V_DISPLAY  = LCD_V_DISPLAY,
  parameter int          BOX_SIZE   = 32,
  parameter int          STEP       = 2,
  parameter int          GRID_SHIFT = 5,
  parameter int          DEB_CYCLES = 250000,
  parameter logic [23:0] BOX_RGB    = 24'h00FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lcd_de,
  input  logic        lcd_vsync,
  input  logic [10:0] pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        key_n,
  output logic [23:0] rgb_data,
  output logic [1:0]  mode,
  output logic        frame_tick
);

  localparam int          BAR_W   = H_DISPLAY / 8;
  localparam logic [10:0] H_LIMIT = 11'(H_DISPLAY);
  localparam logic [9:0]  V_LIMIT = 10'(V_DISPLAY);
  localparam logic [11:0] X_MAX   = 12'(H_DISPLAY - BOX_SIZE);
  localparam logic [10:0] Y_MAX   = 11'(V_DISPLAY - BOX_SIZE);

  logic        press;
  logic        vsync_prev;
  logic [10:0] box_x, box_x_next;
  logic [9:0]  box_y, box_y_next;
  dir_t        dir_x, dir_x_next;
  dir_t        dir_y, dir_y_next;
  logic [1:0]  mode_q, mode_next;
  logic        press_pending, press_pending_next;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_n),
    .press (press)
  );

  // State register. vsync_prev resets low so the first tick after reset
  // always needs a genuine high->low vsync transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev    <= 1'b0;
      frame_tick    <= 1'b0;
      box_x         <= '0;
      box_y         <= '0;
      dir_x         <= DIR_POS;
      dir_y         <= DIR_POS;
      mode_q        <= MODE_BARS;
      press_pending <= 1'b0;
    end else begin
      vsync_prev    <= lcd_vsync;
      frame_tick    <= vsync_prev & ~lcd_vsync;
      box_x         <= box_x_next;
      box_y         <= box_y_next;
      dir_x         <= dir_x_next;
      dir_y         <= dir_y_next;
      mode_q        <= mode_next;
      press_pending <= press_pending_next;
    end
  end

  // Next-state: box bounce and mode stepping, both only on frame_tick.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // skipped an assignment would otherwise infer a latch.
    box_x_next         = box_x;
    box_y_next         = box_y;
    dir_x_next         = dir_x;
    dir_y_next         = dir_y;
    mode_next          = mode_q;
    press_pending_next = press_pending | press;

    if (frame_tick) begin
      if (dir_x == DIR_POS) begin
        if ({1'b0, box_x} + 12'(STEP) >= X_MAX) begin
          box_x_next = X_MAX[10:0];
          dir_x_next = DIR_NEG;
        end else begin
          box_x_next = box_x + 11'(STEP);
        end
      end else begin
        if ({1'b0, box_x} <= 12'(STEP)) begin
          box_x_next = '0;
          dir_x_next = DIR_POS;
        end else begin
          box_x_next = box_x - 11'(STEP);
        end
      end

      if (dir_y == DIR_POS) begin
        if ({1'b0, box_y} + 11'(STEP) >= Y_MAX) begin
          box_y_next = Y_MAX[9:0];
          dir_y_next = DIR_NEG;
        end else begin
          box_y_next = box_y + 10'(STEP);
        end
      end else begin
        if ({1'b0, box_y} <= 11'(STEP)) begin
          box_y_next = '0;
          dir_y_next = DIR_POS;
        end else begin
          box_y_next = box_y - 10'(STEP);
        end
      end

      // Only a press registered before this tick is serviced; a press that
      // lands on the tick cycle itself stays pending for the next frame.
      if (press_pending) begin
        mode_next          = next_mode(mode_q);
        press_pending_next = press;
      end
    end
  end

  assign mode = mode_q;

  // Colour generation, purely combinational from the pixel coordinates.
  logic [2:0] bar_idx;
  logic       in_active;
  logic       on_grid;
  logic       in_box;

  // Comparator chain: thresholds are monotonic, so the last one passed wins.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (pixel_x >= 11'(i * BAR_W)) bar_idx = 3'(i);
    end
  end

  assign in_active = lcd_de && (pixel_x < H_LIMIT) && (pixel_y < V_LIMIT);
  assign on_grid   = (pixel_x[GRID_SHIFT-1:0] == '0) ||
                     (pixel_y[GRID_SHIFT-1:0] == '0);
  assign in_box    = ({1'b0, pixel_x} >= {1'b0, box_x}) &&
                     ({1'b0, pixel_x} <  {1'b0, box_x} + 12'(BOX_SIZE)) &&
                     ({1'b0, pixel_y} >= {1'b0, box_y}) &&
                     ({1'b0, pixel_y} <  {1'b0, box_y} + 11'(BOX_SIZE));

  always_comb begin
    rgb_data = RGB_BLACK;
    if (in_active) begin
      case (mode_q)
        MODE_GRID: rgb_data = on_grid ? RGB_WHITE : RGB_BLACK;
        MODE_BOX:  rgb_data = in_box ? BOX_RGB : RGB_BACKGROUND;
        default:   rgb_data = bar_colour(bar_idx);
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_lcd_pattern_gen
//   Self-checking bench for lcd_pattern_gen: constant vector tables for the
//   static patterns, a reference model for box position and mode, randomized
//   pixel probes, and hand-written key/tick/reset sequences.
// ---------------------------------------------------------------------------
module tb_lcd_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lcd_de;
  logic        lcd_vsync;
  logic [10:0] pixel_x;
  logic [9:0]  pixel_y;
  logic        key_n;
  logic [23:0] rgb_data;
  logic [1:0]  mode;
  logic        frame_tick;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int model_mode    = 0;
  int model_pending = 0;
  int n_ticks       = 0;

  lcd_pattern_gen #(.DEB_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lcd_de     (lcd_de),
    .lcd_vsync  (lcd_vsync),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .key_n      (key_n),
    .rgb_data   (rgb_data),
    .mode       (mode),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        de;
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Triangle wave: 0, STEP, ... max, ..., STEP, 0, ...
  function automatic int tri_pos(input int n, input int max);
    int half = max / 2;
    int p    = n % (2 * half);
    return (p <= half) ? 2 * p : 2 * (2 * half - p);
  endfunction

  function automatic logic [23:0] ref_rgb(input int de, input int x, input int y);
    int bx = tri_pos(n_ticks, 448);
    int by = tri_pos(n_ticks, 240);
    logic [23:0] bars [8];
    bars[0] = 24'hFFFFFF; bars[1] = 24'h00FFFF; bars[2] = 24'hFFFF00; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'h0000FF; bars[6] = 24'hFF0000; bars[7] = 24'h000000;
    if (de == 0 || x >= 480 || y >= 272) return 24'h0;
    case (model_mode)
      1:       return ((x % 32 == 0) || (y % 32 == 0)) ? 24'hFFFFFF : 24'h000000;
      2:       return (x >= bx && x < bx + 32 && y >= by && y < by + 32) ? 24'h00FFFF : 24'h202020;
      default: return bars[x / 60];
    endcase
  endfunction

  task automatic probe(input string name, input int de, input int x, input int y);
    lcd_de  = de[0];
    pixel_x = 11'(x);
    pixel_y = 10'(y);
    #1;
    check(name, {8'h0, rgb_data}, {8'h0, ref_rgb(de, x, y)});
  endtask

  task automatic rand_probe();
    probe("rand_pixel", ($urandom_range(0, 7) != 0) ? 1 : 0,
          int'($urandom_range(0, 520)), int'($urandom_range(0, 290)));
  endtask

  task automatic apply_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      lcd_de  = vecs[i].de;
      pixel_x = 11'(vecs[i].x);
      pixel_y = 10'(vecs[i].y);
      #1;
      check(vecs[i].name, {8'h0, rgb_data}, {8'h0, vecs[i].exp});
    end
  endtask

  // One synthetic frame: a vsync low pulse, then checks of the tick pulse,
  // model update and the mode output.
  task automatic frame();
    lcd_vsync = 1'b0;
    step();
    check("frame_tick_high", {31'h0, frame_tick}, 32'd1);
    lcd_vsync = 1'b1;
    step();
    check("frame_tick_one_cycle", {31'h0, frame_tick}, 32'd0);
    n_ticks++;
    if (model_pending != 0) begin
      model_mode    = (model_mode + 1) % 3;
      model_pending = 0;
    end
    step();
    check("mode", {30'h0, mode}, 32'(model_mode));
  endtask

  // Full press: held well past the debounce time, then a long release.
  task automatic press_key();
    key_n = 1'b0;
    repeat (20) step();
    key_n = 1'b1;
    repeat (30) step();
    model_pending = 1;
  endtask

  initial begin
    int bx;
    int by;

    vecs[0]  = '{"bars_de_low",    1'b0,    0,    0, 24'h000000};
    vecs[1]  = '{"bars_x0",        1'b1,    0,    0, 24'hFFFFFF};
    vecs[2]  = '{"bars_x59",       1'b1,   59,   10, 24'hFFFFFF};
    vecs[3]  = '{"bars_x60",       1'b1,   60,   10, 24'h00FFFF};
    vecs[4]  = '{"bars_x120",      1'b1,  120,    0, 24'hFFFF00};
    vecs[5]  = '{"bars_x239",      1'b1,  239,  100, 24'h00FF00};
    vecs[6]  = '{"bars_x240",      1'b1,  240,  100, 24'hFF00FF};
    vecs[7]  = '{"bars_x300",      1'b1,  300,    5, 24'h0000FF};
    vecs[8]  = '{"bars_x419",      1'b1,  419,  271, 24'hFF0000};
    vecs[9]  = '{"bars_x479",      1'b1,  479,    0, 24'h000000};
    vecs[10] = '{"bars_x2047",     1'b1, 2047,    0, 24'h000000};
    vecs[11] = '{"bars_y272",      1'b1,  100,  272, 24'h000000};
    vecs[12] = '{"bars_y1023",     1'b1,   10, 1023, 24'h000000};
    vecs[13] = '{"grid_32_5",      1'b1,   32,    5, 24'hFFFFFF};
    vecs[14] = '{"grid_33_64",     1'b1,   33,   64, 24'hFFFFFF};
    vecs[15] = '{"grid_33_33",     1'b1,   33,   33, 24'h000000};
    vecs[16] = '{"grid_0_271",     1'b1,    0,  271, 24'hFFFFFF};
    vecs[17] = '{"grid_479_271",   1'b1,  479,  271, 24'h000000};
    vecs[18] = '{"grid_de_low",    1'b0,   32,   32, 24'h000000};
    vecs[19] = '{"grid_x480",      1'b1,  480,    0, 24'h000000};

    rst_n     = 1'b0;
    lcd_de    = 1'b0;
    lcd_vsync = 1'b1;
    pixel_x   = '0;
    pixel_y   = '0;
    key_n     = 1'b1;
    #1;
    check("reset_mode", {30'h0, mode}, 32'd0);
    check("reset_frame_tick", {31'h0, frame_tick}, 32'd0);
    check("reset_rgb_de_low", {8'h0, rgb_data}, 32'h0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    // Bars pattern and the blanking/out-of-range boundaries.
    apply_table(0, 12);
    repeat (10) rand_probe();

    // Short glitch is rejected.
    key_n = 1'b0;
    repeat (10) step();
    key_n = 1'b1;
    repeat (30) step();
    frame();

    // Hold low 20 cycles, then tick: one advance; holding across three
    // more frames gives no further advance.
    key_n = 1'b0;
    repeat (20) step();
    model_pending = 1;
    frame();
    repeat (3) frame();
    key_n = 1'b1;
    repeat (30) step();

    // Grid pattern.
    apply_table(13, 19);
    repeat (10) rand_probe();

    // Into box mode and run past both clamps on both axes.
    press_key();
    frame();
    while (n_ticks < 470) begin
      frame();
      bx = tri_pos(n_ticks, 448);
      by = tri_pos(n_ticks, 240);
      probe("box_top_left_in", 1, bx, by);
      probe("box_bottom_right_in", 1, bx + 31, by + 31);
      probe("box_right_out", 1, bx + 32, by);
      probe("box_below_out", 1, bx, by + 32);
      if (bx > 0) probe("box_left_out", 1, bx - 1, by);
      if (by > 0) probe("box_above_out", 1, bx, by - 1);
      rand_probe();
    end

    // Press completes on the very cycle frame_tick is high: serviced at the
    // following tick, not this one.
    key_n = 1'b0;
    repeat (16) step();
    frame();
    check("same_cycle_press_not_now", {30'h0, mode}, 32'd2);
    model_pending = 1;
    repeat (5) step();
    key_n = 1'b1;
    repeat (30) step();
    frame();

    // Back to box mode, then reset in the middle of a frame.
    press_key();
    frame();
    press_key();
    frame();
    lcd_de  = 1'b1;
    pixel_x = 11'd70;
    pixel_y = 10'd10;
    #2;
    rst_n     = 1'b0;
    lcd_vsync = 1'b0;
    #1;
    check("midframe_reset_mode", {30'h0, mode}, 32'd0);
    check("midframe_reset_tick", {31'h0, frame_tick}, 32'd0);
    check("midframe_reset_rgb", {8'h0, rgb_data}, 32'h00FFFF);
    model_mode    = 0;
    model_pending = 0;
    n_ticks       = 0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("no_tick_after_reset", {31'h0, frame_tick}, 32'd0);
    end
    lcd_vsync = 1'b1;
    step();
    check("no_tick_on_rise", {31'h0, frame_tick}, 32'd0);
    step();
    frame();
    press_key();
    frame();
    press_key();
    frame();
    probe("post_reset_box_in", 1, tri_pos(n_ticks, 448), tri_pos(n_ticks, 240));
    probe("post_reset_box_left_out", 1, tri_pos(n_ticks, 448) - 1, tri_pos(n_ticks, 240));
    probe("post_reset_origin_out", 1, 0, 0);
    repeat (10) rand_probe();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
